multi_ch_prescale_counter: RTL and testbench

//   Parametrised bank of NUM_CH independent W-bit event counters. Each channel has
//   its own runtime-programmable prescaler: the counter advances once every
//   (div+1) enabled cycles. Each channel has a per-channel terminal-count pulse.
//   A selected-channel readback port is provided. The block sits beside the

---
 rtl/multi_ch_prescale_counter.sv | 55 +++++
 tb/tb_multi_ch_prescale_counter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/multi_ch_prescale_counter.sv
// multi_ch_prescale_counter: bank of NUM_CH W-bit event counters, each with a
// runtime-programmable prescaler, a terminal-count pulse and a selected-channel readback.
module multi_ch_prescale_counter #(
   parameter int NUM_CH   = 4,
   parameter int SEL_W    = 2,
   parameter int W        = 64,
   parameter int PW       = 8,
   parameter int DIV_RST  = 3,
   parameter int SATURATE = 0
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                En,
   input  logic [SEL_W-1:0]    Slt,
   input  logic                Clr,
   input  logic                CfgWe,
   input  logic [PW-1:0]       CfgDiv,
   output logic [NUM_CH*W-1:0] Count_flat,
   output logic [W-1:0]        Sel_count,
   output logic [NUM_CH-1:0]   Tc
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [W-1:0]  cnt;
      logic [PW-1:0] pre, div;
      logic          sel, inc;
      assign sel = Slt == SEL_W'(i);
      // an increment event needs plain En on this channel with the prescaler at its divisor
      assign inc = sel && En && !Clr && !CfgWe && pre == div;
      always_ff @(posedge Clk or posedge Reset)
         if (Reset) begin
            cnt   <= '0;
            pre   <= '0;
            div   <= PW'(DIV_RST);
            Tc[i] <= 1'b0;
         end else begin
            Tc[i] <= inc && &cnt;
            if (sel && Clr) begin
               cnt <= '0;
               pre <= '0;
            end else if (sel && CfgWe) begin
               div <= CfgDiv;
               pre <= '0;
            end else if (sel && En) begin
               pre <= pre == div ? '0 : pre + 1'b1;
               if (inc && !(SATURATE != 0 && &cnt)) cnt <= cnt + 1'b1;
            end
         end
      assign Count_flat[i*W +: W] = cnt;
   end
   always_comb begin
      Sel_count = '0;
      for (int i = 0; i < NUM_CH; i++)
         Sel_count = Slt == SEL_W'(i) ? Count_flat[i*W +: W] : Sel_count;
   end
endmodule

// File: tb/tb_multi_ch_prescale_counter.sv
// tb_multi_ch_prescale_counter: directed checks of the main 64-bit bank plus
// two 4-bit instances (wrap and saturate) with a 3-bit channel select.
module tb_multi_ch_prescale_counter;
   logic Clk = 1'b0, Reset = 1'b1;
   always #5 Clk = ~Clk;
   logic en = 0, clr = 0, cfg_we = 0;
   logic [1:0] slt = 0;
   logic [7:0] cfg_div = 0;
   logic [255:0] cf;
   logic [63:0] sc;
   logic [3:0] tc;
   logic b_en = 0, b_clr = 0, b_we = 0;
   logic [2:0] b_slt = 0;
   logic [7:0] b_div = 0;
   logic [15:0] s0_cf, s1_cf;
   logic [3:0] s0_sc, s1_sc, s0_tc, s1_tc;
   int tests = 0, fails = 0;

   multi_ch_prescale_counter u_main (
      .Clk(Clk), .Reset(Reset), .En(en), .Slt(slt), .Clr(clr), .CfgWe(cfg_we),
      .CfgDiv(cfg_div), .Count_flat(cf), .Sel_count(sc), .Tc(tc));
   multi_ch_prescale_counter #(.SEL_W(3), .W(4), .SATURATE(0)) u_s0 (
      .Clk(Clk), .Reset(Reset), .En(b_en), .Slt(b_slt), .Clr(b_clr), .CfgWe(b_we),
      .CfgDiv(b_div), .Count_flat(s0_cf), .Sel_count(s0_sc), .Tc(s0_tc));
   multi_ch_prescale_counter #(.SEL_W(3), .W(4), .SATURATE(1)) u_s1 (
      .Clk(Clk), .Reset(Reset), .En(b_en), .Slt(b_slt), .Clr(b_clr), .CfgWe(b_we),
      .CfgDiv(b_div), .Count_flat(s1_cf), .Sel_count(s1_sc), .Tc(s1_tc));

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      #2;
      chk("reset_cf", cf, 0);
      chk("reset_tc", tc, 0);
      chk("reset_sc", sc, 0);
      chk("reset_s0", s0_cf, 0);
      chk("reset_s1", s1_cf, 0);
      tick();
      Reset = 0;
      slt = 0; en = 1;
      tick(4);
      chk("t1_after4", cf, 256'd1);
      tick(4);
      chk("t1_after8", cf, 256'd2);
      chk("t1_tc", tc, 0);
      slt = 1; cfg_we = 1; cfg_div = 0;
      tick();
      chk("t2_cfg_nocount", cf, 256'd2);
      cfg_we = 0;
      tick(5);
      chk("t2_cnt1", cf, {64'd0, 64'd0, 64'd5, 64'd2});
      chk("t2_sel", sc, 64'd5);
      slt = 2;
      tick(2);
      en = 0;
      tick(3);
      slt = 0; en = 1;
      tick(2);
      slt = 2;
      tick();
      chk("t3_pre3", cf, {64'd0, 64'd0, 64'd5, 64'd2});
      tick();
      chk("t3_cnt2", cf, {64'd0, 64'd1, 64'd5, 64'd2});
      chk("t3_sel", sc, 64'd1);
      slt = 0; cfg_we = 1; cfg_div = 0;
      tick();
      cfg_we = 0;
      tick(5);
      chk("t5_cnt7", cf, {64'd0, 64'd1, 64'd5, 64'd7});
      clr = 1; cfg_we = 1; cfg_div = 5;
      tick();
      chk("t5_clr", cf, {64'd0, 64'd1, 64'd5, 64'd0});
      chk("t5_tc", tc, 0);
      clr = 0; cfg_we = 0;
      tick();
      chk("t5_div_kept", cf, {64'd0, 64'd1, 64'd5, 64'd1});
      en = 0;
      b_slt = 0; b_we = 1; b_div = 0; b_en = 1;
      tick();
      b_we = 0;
      tick(15);
      chk("t4_s0_15", s0_cf, 16'h000f);
      chk("t4_s1_15", s1_cf, 16'h000f);
      chk("t4_s0_tc15", s0_tc, 0);
      chk("t4_s1_tc15", s1_tc, 0);
      tick();
      chk("t4_s0_wrap", s0_cf, 16'h0000);
      chk("t4_s0_tc16", s0_tc, 4'b0001);
      chk("t4_s1_hold", s1_cf, 16'h000f);
      chk("t4_s1_tc16", s1_tc, 4'b0001);
      tick();
      chk("t4_s0_17", s0_cf, 16'h0001);
      chk("t4_s0_tc17", s0_tc, 0);
      chk("t4_s1_17", s1_cf, 16'h000f);
      chk("t4_s1_tc17", s1_tc, 4'b0001);
      b_en = 0;
      tick();
      chk("t4_s1_tc_off", s1_tc, 0);
      b_slt = 5; b_en = 1; b_clr = 1; b_we = 1; b_div = 7;
      tick(2);
      chk("t6_oor_s0", s0_cf, 16'h0001);
      chk("t6_oor_s1", s1_cf, 16'h000f);
      chk("t6_oor_sc0", s0_sc, 0);
      chk("t6_oor_sc1", s1_sc, 0);
      b_slt = 0; b_clr = 0; b_we = 0; b_en = 0;
      #1;
      chk("t6_sel_back", s0_sc, 4'd1);
      b_en = 1;
      tick();
      chk("t6_div_kept", s0_cf, 16'h0002);
      b_en = 0;
      slt = 3; en = 1;
      tick(38);
      chk("t6_cnt3", cf, {64'd9, 64'd1, 64'd5, 64'd1});
      en = 0;
      #3 Reset = 1;
      #1;
      chk("t6_async_cf", cf, 0);
      chk("t6_async_tc", tc, 0);
      chk("t6_async_s0", s0_cf, 0);
      #1 Reset = 0;
      en = 1;
      tick(3);
      chk("t6_div_rst3", cf, 0);
      tick();
      chk("t6_div_rst4", cf, {64'd1, 192'd0});
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
